flash_status_transmitter: RTL

FLASH_STATUS_TRANSMITTER -- requirements
Module: flash_status_transmitter

---
 rtl/flash_cmd_pkg.sv | 96 +++++++++
 rtl/flash_evt_capture.sv | 35 +++
 rtl/flash_status_transmitter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/flash_cmd_pkg.sv
// Shared constants and types for the flash command/status path.
// Holds the response opcodes, word index codes, event numbering,
// the transmitter FSM state type and the frame builder used by the status transmitter.
package flash_cmd_pkg;

    localparam int unsigned ADDR_W    = 24;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned SEQ_W     = 8;
    localparam int unsigned NUM_EVT   = 5;
    localparam int unsigned EVT_IDX_W = 3;

    // Response opcodes
    localparam logic [7:0] OP_READ    = 8'hAD;
    localparam logic [7:0] OP_ERASE   = 8'hAE;
    localparam logic [7:0] OP_INIT    = 8'hAF;
    localparam logic [7:0] OP_WRITE   = 8'hAC;
    localparam logic [7:0] OP_TIMEOUT = 8'hEF;

    // Word index codes
    localparam logic [7:0] IDX_WORD0  = 8'h00;
    localparam logic [7:0] IDX_WORD1  = 8'h01;
    localparam logic [7:0] IDX_SINGLE = 8'hFF;

    // Event numbering; lower number means higher arbitration priority
    localparam logic [EVT_IDX_W-1:0] EVT_TIMEOUT = 3'd0;
    localparam logic [EVT_IDX_W-1:0] EVT_ERASE   = 3'd1;
    localparam logic [EVT_IDX_W-1:0] EVT_READ    = 3'd2;
    localparam logic [EVT_IDX_W-1:0] EVT_WRITE   = 3'd3;
    localparam logic [EVT_IDX_W-1:0] EVT_INIT    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND0 = 2'd1,
        ST_SEND1 = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  index;
        logic [15:0] payload;
    } tx_word_t;

    typedef struct packed {
        tx_word_t word0;
        tx_word_t word1;
        logic     two_word;
    } tx_frame_t;

    // Assemble one response word from its four bytes
    function automatic tx_word_t mk_word(input logic [7:0] op, input logic [7:0] idx,
                                         input logic [7:0] hi, input logic [7:0] lo);
        tx_word_t w;
        w.opcode  = op;
        w.index   = idx;
        w.payload = {hi, lo};
        return w;
    endfunction

    // Highest-priority pending event (only meaningful when pend is non-zero)
    function automatic logic [EVT_IDX_W-1:0] pick_winner(input logic [NUM_EVT-1:0] pend);
        logic [EVT_IDX_W-1:0] w;
        w = EVT_TIMEOUT;
        if (pend[EVT_TIMEOUT])    w = EVT_TIMEOUT;
        else if (pend[EVT_ERASE]) w = EVT_ERASE;
        else if (pend[EVT_READ])  w = EVT_READ;
        else if (pend[EVT_WRITE]) w = EVT_WRITE;
        else if (pend[EVT_INIT])  w = EVT_INIT;
        return w;
    endfunction

    // Full frame for an event; address bytes go out low byte first
    function automatic tx_frame_t build_frame(input logic [EVT_IDX_W-1:0] evt,
                                              input logic [ADDR_W-1:0]    addr,
                                              input logic [SEQ_W-1:0]     seq);
        tx_frame_t f;
        f = '0;
        case (evt)
            EVT_TIMEOUT: f.word0 = mk_word(OP_TIMEOUT, IDX_WORD0, 8'h00, seq);
            EVT_READ:    f.word0 = mk_word(OP_READ, IDX_SINGLE, 8'h00, seq);
            EVT_INIT:    f.word0 = mk_word(OP_INIT, IDX_SINGLE, 8'h00, seq);
            EVT_ERASE: begin
                f.word0    = mk_word(OP_ERASE, IDX_WORD0, addr[7:0], addr[15:8]);
                f.word1    = mk_word(OP_ERASE, IDX_WORD1, addr[23:16], seq);
                f.two_word = 1'b1;
            end
            EVT_WRITE: begin
                f.word0    = mk_word(OP_WRITE, IDX_WORD0, addr[7:0], addr[15:8]);
                f.word1    = mk_word(OP_WRITE, IDX_WORD1, addr[23:16], seq);
                f.two_word = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/flash_evt_capture.sv
// Rising-edge event capture for one completion source.
// Ports: clk, rst (async, active-high); evt_in level input; clr takes the pending event;
// pending (registered) flag; edge_c combinational rise strobe; coalesce_c combinational
// strobe when a new rise lands on a flag that is still pending and not being taken.
module flash_evt_capture (
    input  logic clk,
    input  logic rst,
    input  logic evt_in,
    input  logic clr,
    output logic pending,
    output logic edge_c,
    output logic coalesce_c
);

    logic sample_q;
    logic prev_q;

    // Input is sampled first so the edge is judged on two registered samples
    assign edge_c     = sample_q & ~prev_q;
    assign coalesce_c = edge_c & pending & ~clr;

    // Sample history and pending flag; a rise beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
            pending  <= 1'b0;
        end else begin
            sample_q <= evt_in;
            prev_q   <= sample_q;
            pending  <= edge_c | (pending & ~clr);
        end
    end

endmodule

// File: rtl/flash_status_transmitter.sv
// Turns completion/timeout levels from the flash operation blocks into response frames.
// Ports: clk, rst (async, active-high); end_read, end_erase, end_write, end_init_flash_addr,
// flash_cmd_incomplete completion levels; erase_addr_finish / cur_write_addr row addresses;
// tx_data/tx_valid/tx_ready word handshake; evt_overrun sticky coalesce flag; busy while sending.
module flash_status_transmitter
    import flash_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        end_read,
    input  logic        end_erase,
    input  logic        end_write,
    input  logic        end_init_flash_addr,
    input  logic        flash_cmd_incomplete,
    input  logic [23:0] erase_addr_finish,
    input  logic [23:0] cur_write_addr,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        evt_overrun,
    output logic        busy
);

    logic [NUM_EVT-1:0]   evt_vec;
    logic [NUM_EVT-1:0]   pending;
    logic [NUM_EVT-1:0]   edge_c;
    logic [NUM_EVT-1:0]   coalesce_c;
    logic [NUM_EVT-1:0]   clr;

    tx_state_e            state, state_n;
    logic [SEQ_W-1:0]     seq, seq_n;
    tx_word_t             word1_q, word1_n;
    logic                 two_word_q, two_word_n;
    tx_word_t             tx_data_n;
    logic                 tx_valid_n;
    logic                 busy_n;
    logic [ADDR_W-1:0]    erase_addr_q;
    logic [ADDR_W-1:0]    write_addr_q;

    logic [EVT_IDX_W-1:0] winner;
    logic [ADDR_W-1:0]    win_addr;
    tx_frame_t            frame;

    assign evt_vec[EVT_TIMEOUT] = flash_cmd_incomplete;
    assign evt_vec[EVT_ERASE]   = end_erase;
    assign evt_vec[EVT_READ]    = end_read;
    assign evt_vec[EVT_WRITE]   = end_write;
    assign evt_vec[EVT_INIT]    = end_init_flash_addr;

    // One capture slice per event source
    for (genvar g = 0; g < int'(NUM_EVT); g++) begin : g_cap
        flash_evt_capture u_cap (
            .clk        (clk),
            .rst        (rst),
            .evt_in     (evt_vec[g]),
            .clr        (clr[g]),
            .pending    (pending[g]),
            .edge_c     (edge_c[g]),
            .coalesce_c (coalesce_c[g])
        );
    end

    // Pending addresses follow the newest edge; overrun is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erase_addr_q <= '0;
            write_addr_q <= '0;
            evt_overrun  <= 1'b0;
        end else begin
            if (edge_c[EVT_ERASE]) erase_addr_q <= erase_addr_finish;
            if (edge_c[EVT_WRITE]) write_addr_q <= cur_write_addr;
            evt_overrun <= evt_overrun | (|coalesce_c);
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            seq        <= '0;
            word1_q    <= '0;
            two_word_q <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            seq        <= seq_n;
            word1_q    <= word1_n;
            two_word_q <= two_word_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            busy       <= busy_n;
        end
    end

    // Next-state and output logic; the frame is frozen into registers at load
    always_comb begin
        state_n    = state;
        seq_n      = seq;
        word1_n    = word1_q;
        two_word_n = two_word_q;
        tx_data_n  = tx_word_t'(tx_data);
        tx_valid_n = tx_valid;
        busy_n     = busy;
        clr        = '0;

        winner   = pick_winner(pending);
        win_addr = (winner == EVT_ERASE) ? erase_addr_q : write_addr_q;
        frame    = build_frame(winner, win_addr, seq);

        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    clr[winner] = 1'b1;
                    tx_data_n   = frame.word0;
                    word1_n     = frame.word1;
                    two_word_n  = frame.two_word;
                    tx_valid_n  = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = ST_SEND0;
                end
            end
            ST_SEND0: begin
                if (tx_ready) begin
                    if (two_word_q) begin
                        tx_data_n = word1_q;
                        state_n   = ST_SEND1;
                    end else begin
                        tx_valid_n = 1'b0;
                        busy_n     = 1'b0;
                        seq_n      = seq + SEQ_W'(1);
                        state_n    = ST_IDLE;
                    end
                end
            end
            ST_SEND1: begin
                if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    busy_n     = 1'b0;
                    seq_n      = seq + SEQ_W'(1);
                    state_n    = ST_IDLE;
                end
            end
            default: begin
                tx_valid_n = 1'b0;
                busy_n     = 1'b0;
                state_n    = ST_IDLE;
            end
        endcase
    end

endmodule
